// File: rtl/ctrl.sv
// Pipeline control: redirect, hold and flush sequencing for pc_reg/if_id/id_ex.
// Define CTRL_PERF_CNT_EN to build the saturating jump/hold cycle counters.
module ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    input  logic        hold_ext_i,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic        hold_o,
    output logic        flush_o,
    output logic [31:0] jump_cnt_o,
    output logic [31:0] hold_cnt_o
);

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StPend
    } state_e;

    // Counter holds the flush cycles still owed after the redirect cycle itself.
    localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES - 1);
    localparam state_e     RedirNext = (FLUSH_CYCLES > 1) ? StFlush : StIdle;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] pend_addr_q, pend_addr_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            pend_addr_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_addr_d = pend_addr_q;
        jump_en_o   = 1'b0;
        jump_addr_o = 32'd0;
        hold_o      = hold_flag_i | hold_ext_i;
        flush_o     = 1'b0;

        case (state_q)
            StIdle: begin
                if (jump_en_i) begin
                    if (hold_ext_i) begin
                        pend_addr_d = jump_addr_i;
                        hold_o      = 1'b1;
                        state_d     = StPend;
                    end else begin
                        jump_en_o   = 1'b1;
                        jump_addr_o = jump_addr_i;
                        flush_o     = 1'b1;
                        hold_o      = 1'b0;
                        cnt_d       = FlushInit;
                        state_d     = RedirNext;
                    end
                end
            end
            StFlush: begin
                flush_o = 1'b1;
                cnt_d   = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = StIdle;
                end
            end
            StPend: begin
                // hold_o already 1 via hold_ext_i while the bus side stalls.
                if (!hold_ext_i) begin
                    jump_en_o   = 1'b1;
                    jump_addr_o = pend_addr_q;
                    flush_o     = 1'b1;
                    hold_o      = 1'b0;
                    cnt_d       = FlushInit;
                    state_d     = RedirNext;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (!rst_n) begin
            jump_en_o   = 1'b0;
            jump_addr_o = 32'd0;
            hold_o      = 1'b0;
            flush_o     = 1'b0;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] jump_cnt_q, hold_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            jump_cnt_q <= 32'd0;
            hold_cnt_q <= 32'd0;
        end else begin
            if (jump_en_o && (jump_cnt_q != 32'hFFFF_FFFF)) begin
                jump_cnt_q <= jump_cnt_q + 32'd1;
            end
            if (hold_o && (hold_cnt_q != 32'hFFFF_FFFF)) begin
                hold_cnt_q <= hold_cnt_q + 32'd1;
            end
        end
    end

    assign jump_cnt_o = jump_cnt_q;
    assign hold_cnt_o = hold_cnt_q;
`else
    assign jump_cnt_o = 32'd0;
    assign hold_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_ctrl.sv
// Bench for ctrl: two instances (FLUSH_CYCLES 2 and 3) checked every cycle against
// a redirect/flush/hold model, plus directed literal expectations.
module tb_ctrl;

    localparam int unsigned Fc0 = 2;
    localparam int unsigned Fc1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        hold_flag_i;
    logic        hold_ext_i;

    logic [1:0]       dut_je, dut_ho, dut_fl;
    logic [1:0][31:0] dut_ja, dut_jc, dut_hc;

    ctrl #(.FLUSH_CYCLES(Fc0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .hold_flag_i(hold_flag_i), .hold_ext_i(hold_ext_i), .jump_en_o(dut_je[0]),
        .jump_addr_o(dut_ja[0]), .hold_o(dut_ho[0]), .flush_o(dut_fl[0]),
        .jump_cnt_o(dut_jc[0]), .hold_cnt_o(dut_hc[0])
    );

    ctrl #(.FLUSH_CYCLES(Fc1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .hold_flag_i(hold_flag_i), .hold_ext_i(hold_ext_i), .jump_en_o(dut_je[1]),
        .jump_addr_o(dut_ja[1]), .hold_o(dut_ho[1]), .flush_o(dut_fl[1]),
        .jump_cnt_o(dut_jc[1]), .hold_cnt_o(dut_hc[1])
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: flush cycles still owed, a parked redirect, and event counts.
    int          m_flush_left [2];
    bit          m_pend       [2];
    logic [31:0] m_pend_addr  [2];
    logic [31:0] m_jc         [2];
    logic [31:0] m_hc         [2];

    logic [1:0]       x_je, x_ho, x_fl;
    logic [1:0][31:0] x_ja;

    always_comb begin
        x_je = '0;
        x_ho = '0;
        x_fl = '0;
        x_ja = '0;
        for (int i = 0; i < 2; i++) begin
            if (rst_n) begin
                if (m_flush_left[i] > 0) begin
                    x_fl[i] = 1'b1;
                    x_ho[i] = hold_flag_i | hold_ext_i;
                end else if (m_pend[i] || jump_en_i) begin
                    if (hold_ext_i) begin
                        x_ho[i] = 1'b1;
                    end else begin
                        x_je[i] = 1'b1;
                        x_fl[i] = 1'b1;
                        x_ja[i] = m_pend[i] ? m_pend_addr[i] : jump_addr_i;
                    end
                end else begin
                    x_ho[i] = hold_flag_i | hold_ext_i;
                end
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_flush_left[i] <= 0;
                m_pend[i]       <= 1'b0;
                m_pend_addr[i]  <= 32'd0;
                m_jc[i]         <= 32'd0;
                m_hc[i]         <= 32'd0;
            end else begin
                if (x_je[i] && m_jc[i] != 32'hFFFF_FFFF) m_jc[i] <= m_jc[i] + 32'd1;
                if (x_ho[i] && m_hc[i] != 32'hFFFF_FFFF) m_hc[i] <= m_hc[i] + 32'd1;
                if (m_flush_left[i] > 0) begin
                    m_flush_left[i] <= m_flush_left[i] - 1;
                end else if (x_je[i]) begin
                    m_pend[i]       <= 1'b0;
                    m_flush_left[i] <= int'(((i == 0) ? Fc0 : Fc1) - 1);
                end else if (!m_pend[i] && jump_en_i && hold_ext_i) begin
                    m_pend[i]      <= 1'b1;
                    m_pend_addr[i] <= jump_addr_i;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk1($sformatf("jump_en[%0d]", i), dut_je[i], x_je[i]);
                chk32($sformatf("jump_addr[%0d]", i), dut_ja[i], x_ja[i]);
                chk1($sformatf("hold[%0d]", i), dut_ho[i], x_ho[i]);
                chk1($sformatf("flush[%0d]", i), dut_fl[i], x_fl[i]);
`ifdef CTRL_PERF_CNT_EN
                chk32($sformatf("jump_cnt[%0d]", i), dut_jc[i], m_jc[i]);
                chk32($sformatf("hold_cnt[%0d]", i), dut_hc[i], m_hc[i]);
`else
                chk32($sformatf("jump_cnt[%0d]", i), dut_jc[i], 32'd0);
                chk32($sformatf("hold_cnt[%0d]", i), dut_hc[i], 32'd0);
`endif
            end
        end
    end

    // Apply one cycle of inputs just after the edge, return at the mid-cycle sample point.
    task automatic step(input bit r, input bit je, input logic [31:0] a, input bit hf,
                        input bit he);
        @(posedge clk);
        #1;
        rst_n       = r;
        jump_en_i   = je;
        jump_addr_i = a;
        hold_flag_i = hf;
        hold_ext_i  = he;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n       = 1'b0;
        jump_en_i   = 1'b1;
        jump_addr_i = 32'hDEAD_BEEF;
        hold_flag_i = 1'b1;
        hold_ext_i  = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk1("rst_jump_en", dut_je[0], 1'b0);
        chk32("rst_jump_addr", dut_ja[0], 32'd0);
        chk1("rst_hold", dut_ho[0], 1'b0);
        chk1("rst_flush", dut_fl[0], 1'b0);
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
        idle(1);
        chk32("rst_jump_cnt", dut_jc[0], 32'd0);
        chk32("rst_hold_cnt", dut_hc[0], 32'd0);

        // Immediate redirect, flush length 2 vs 3.
        step(1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
        chk1("jmp_c0_en", dut_je[0], 1'b1);
        chk32("jmp_c0_addr", dut_ja[0], 32'h100);
        chk1("jmp_c0_flush", dut_fl[0], 1'b1);
        chk1("jmp_c0_hold", dut_ho[0], 1'b0);
        idle(1);
        chk1("jmp_c1_flush", dut_fl[0], 1'b1);
        chk1("jmp_c1_en", dut_je[0], 1'b0);
        chk32("jmp_c1_addr", dut_ja[0], 32'd0);
        idle(1);
        chk1("jmp_c2_flush2", dut_fl[0], 1'b0);
        chk1("jmp_c2_flush3", dut_fl[1], 1'b1);
        idle(1);
        chk1("jmp_c3_flush3", dut_fl[1], 1'b0);

        // Redirect requests during FLUSH are ignored (FLUSH_CYCLES=3 instance).
        step(1'b1, 1'b1, 32'h0000_0300, 1'b0, 1'b0);
        chk32("fl3_c0_addr", dut_ja[1], 32'h300);
        step(1'b1, 1'b1, 32'h0000_0400, 1'b0, 1'b0);
        chk1("fl3_c1_en", dut_je[1], 1'b0);
        chk1("fl3_c1_flush", dut_fl[1], 1'b1);
        step(1'b1, 1'b1, 32'h0000_0500, 1'b0, 1'b0);
        chk1("fl3_c2_en", dut_je[1], 1'b0);
        chk1("fl3_c2_flush", dut_fl[1], 1'b1);
        chk32("fl2_c2_addr", dut_ja[0], 32'h500);
        idle(1);
        chk1("fl3_c3_flush", dut_fl[1], 1'b0);
        idle(2);

        // Redirect beats hold_flag_i.
        step(1'b1, 1'b1, 32'h0000_0600, 1'b1, 1'b0);
        chk1("jh_en", dut_je[0], 1'b1);
        chk1("jh_hold", dut_ho[0], 1'b0);
        chk1("jh_flush", dut_fl[0], 1'b1);
        idle(3);

        // Redirect parked behind an external hold.
        step(1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b1);
        chk1("pend_c0_hold", dut_ho[0], 1'b1);
        chk1("pend_c0_en", dut_je[0], 1'b0);
        chk1("pend_c0_flush", dut_fl[0], 1'b0);
        step(1'b1, 1'b1, 32'h0000_0999, 1'b0, 1'b1);
        chk1("pend_c1_hold", dut_ho[0], 1'b1);
        chk1("pend_c1_en", dut_je[0], 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        chk1("pend_c2_hold", dut_ho[0], 1'b1);
        idle(1);
        chk1("pend_c3_en", dut_je[0], 1'b1);
        chk32("pend_c3_addr", dut_ja[0], 32'h200);
        chk1("pend_c3_flush", dut_fl[0], 1'b1);
        chk1("pend_c3_hold", dut_ho[0], 1'b0);
        idle(3);

        // Reset while parked drops the redirect.
        step(1'b1, 1'b1, 32'h0000_0700, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        chk1("rp_rst_hold", dut_ho[0], 1'b0);
        idle(1);
        chk1("rp_en", dut_je[0], 1'b0);
        chk1("rp_flush", dut_fl[0], 1'b0);
        chk32("rp_jump_cnt", dut_jc[0], 32'd0);
        chk32("rp_hold_cnt", dut_hc[0], 32'd0);
        idle(1);
        chk1("rp_en_later", dut_je[1], 1'b0);

        // Four redirects then five hold cycles.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 32'h0000_1000 + 32'(k), 1'b0, 1'b0);
            idle(4);
        end
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        idle(1);
`ifdef CTRL_PERF_CNT_EN
        chk32("perf_jump_cnt", dut_jc[1], 32'd4);
        chk32("perf_hold_cnt", dut_hc[1], 32'd5);
`else
        chk32("perf_jump_cnt", dut_jc[1], 32'd0);
        chk32("perf_hold_cnt", dut_hc[1], 32'd0);
`endif

        for (int k = 0; k < 300; k++) begin
            step($urandom_range(0, 49) != 0, $urandom_range(0, 3) == 0, $urandom,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        end
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
